min_max_ctrl: RTL and testbench



---
 rtl/min_max_ctrl.sv | 171 +++++++++++++++++
 tb/tb_min_max_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/min_max_ctrl.sv
// min_max_ctrl
// Control stage that feeds min_max_top. It holds a checked min/max/com
// configuration, generates the blink oscillator and supplies the displayed
// value, either passed through from val_i or swept between min and max.
//
// Ports
//   clk_i      system clock, all state on the rising edge
//   rst_i      synchronous reset, active high
//   load_i     one-cycle strobe that samples cfg_com_i/cfg_min_i/cfg_max_i
//   cfg_com_i  requested mode (00 normal, 01 linear, 10 all off, 11 all on)
//   cfg_min_i  requested lower bound
//   cfg_max_i  requested upper bound
//   val_i      external value used in pass-through mode
//   sweep_i    1 = internal up/down sweep, 0 = pass-through of val_i
//   osc_en_i   1 = blink enabled, 0 = osc_o held low
//   com_o      mode to min_max_top
//   min_o      lower bound to min_max_top
//   max_o      upper bound to min_max_top
//   val_o      displayed value to min_max_top
//   osc_o      blink oscillator to min_max_top
//   cfg_err_o  sticky flag: the last load was rejected
//
// Value FSM
//   state | meaning
//   HOLD  | val_o follows val_i with one cycle of latency
//   UP    | sweeping upward, one step every SWEEP_DIV cycles
//   DOWN  | sweeping downward, one step every SWEEP_DIV cycles

module min_max_ctrl #(
    parameter int VALSIZE   = 4,
    parameter int OSC_DIV   = 4,
    parameter int SWEEP_DIV = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [1:0]         cfg_com_i,
    input  logic [VALSIZE-1:0] cfg_min_i,
    input  logic [VALSIZE-1:0] cfg_max_i,
    input  logic [VALSIZE-1:0] val_i,
    input  logic               sweep_i,
    input  logic               osc_en_i,
    output logic [1:0]         com_o,
    output logic [VALSIZE-1:0] min_o,
    output logic [VALSIZE-1:0] max_o,
    output logic [VALSIZE-1:0] val_o,
    output logic               osc_o,
    output logic               cfg_err_o
);

    // Counter widths stay at least one bit so a divider of 1 still builds.
    localparam int OSC_W   = (OSC_DIV   > 1) ? $clog2(OSC_DIV)   : 1;
    localparam int SWEEP_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;

    localparam logic [OSC_W-1:0]   OSC_LAST   = OSC_W'(OSC_DIV - 1);
    localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(SWEEP_DIV - 1);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t               state_q;
    logic [1:0]           com_q;
    logic [VALSIZE-1:0]   min_q;
    logic [VALSIZE-1:0]   max_q;
    logic [VALSIZE-1:0]   val_q;
    logic                 osc_q;
    logic                 err_q;
    logic [OSC_W-1:0]     osc_cnt_q;
    logic [SWEEP_W-1:0]   sweep_cnt_q;

    logic                 load_ok_d;
    logic [VALSIZE-1:0]   val_inc_d;
    logic [VALSIZE-1:0]   val_dec_d;

    // Strict compare keeps min_o < max_o, which also keeps the sweep from
    // ever wrapping around the value range.
    assign load_ok_d = load_i && (cfg_min_i < cfg_max_i);
    assign val_inc_d = val_q + VALSIZE'(1);
    assign val_dec_d = val_q - VALSIZE'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= HOLD;
            com_q       <= 2'b10;
            min_q       <= '0;
            max_q       <= '1;
            val_q       <= '0;
            osc_q       <= 1'b0;
            err_q       <= 1'b0;
            osc_cnt_q   <= '0;
            sweep_cnt_q <= '0;
        end else begin
            // Configuration registers
            if (load_ok_d) begin
                com_q <= cfg_com_i;
                min_q <= cfg_min_i;
                max_q <= cfg_max_i;
                err_q <= 1'b0;
            end else if (load_i) begin
                err_q <= 1'b1;
            end

            // Oscillator; disable wins over the phase restart of a load
            if (!osc_en_i) begin
                osc_q     <= 1'b0;
                osc_cnt_q <= '0;
            end else if (load_ok_d) begin
                osc_q     <= 1'b1;
                osc_cnt_q <= '0;
            end else if (osc_cnt_q == OSC_LAST) begin
                osc_q     <= ~osc_q;
                osc_cnt_q <= '0;
            end else begin
                osc_cnt_q <= osc_cnt_q + OSC_W'(1);
            end

            // Value FSM
            case (state_q)
                HOLD: begin
                    if (sweep_i) begin
                        state_q     <= UP;
                        // A load in the same edge already defines the new min.
                        val_q       <= load_ok_d ? cfg_min_i : min_q;
                        sweep_cnt_q <= '0;
                    end else begin
                        val_q <= val_i;
                    end
                end
                UP, DOWN: begin
                    if (!sweep_i) begin
                        state_q     <= HOLD;
                        val_q       <= val_i;
                        sweep_cnt_q <= '0;
                    end else if (load_ok_d) begin
                        state_q     <= UP;
                        val_q       <= cfg_min_i;
                        sweep_cnt_q <= '0;
                    end else if (sweep_cnt_q == SWEEP_LAST) begin
                        sweep_cnt_q <= '0;
                        // Turn around on the step that lands on the bound so
                        // each bound is shown for a full step period.
                        if (state_q == UP) begin
                            val_q <= val_inc_d;
                            if (val_inc_d == max_q) state_q <= DOWN;
                        end else begin
                            val_q <= val_dec_d;
                            if (val_dec_d == min_q) state_q <= UP;
                        end
                    end else begin
                        sweep_cnt_q <= sweep_cnt_q + SWEEP_W'(1);
                    end
                end
                default: begin
                    state_q     <= HOLD;
                    sweep_cnt_q <= '0;
                end
            endcase
        end
    end

    assign com_o     = com_q;
    assign min_o     = min_q;
    assign max_o     = max_q;
    assign val_o     = val_q;
    assign osc_o     = osc_q;
    assign cfg_err_o = err_q;

endmodule

// File: tb/tb_min_max_ctrl.sv
// tb_min_max_ctrl
// Directed bench for min_max_ctrl with VALSIZE=4, OSC_DIV=4, SWEEP_DIV=2.
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_min_max_ctrl;

    localparam int VALSIZE   = 4;
    localparam int OSC_DIV   = 4;
    localparam int SWEEP_DIV = 2;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               load_i;
    logic [1:0]         cfg_com_i;
    logic [VALSIZE-1:0] cfg_min_i;
    logic [VALSIZE-1:0] cfg_max_i;
    logic [VALSIZE-1:0] val_i;
    logic               sweep_i;
    logic               osc_en_i;
    logic [1:0]         com_o;
    logic [VALSIZE-1:0] min_o;
    logic [VALSIZE-1:0] max_o;
    logic [VALSIZE-1:0] val_o;
    logic               osc_o;
    logic               cfg_err_o;

    int n_checks = 0;
    int n_errors = 0;

    min_max_ctrl #(
        .VALSIZE   (VALSIZE),
        .OSC_DIV   (OSC_DIV),
        .SWEEP_DIV (SWEEP_DIV)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (load_i),
        .cfg_com_i (cfg_com_i),
        .cfg_min_i (cfg_min_i),
        .cfg_max_i (cfg_max_i),
        .val_i     (val_i),
        .sweep_i   (sweep_i),
        .osc_en_i  (osc_en_i),
        .com_o     (com_o),
        .min_o     (min_o),
        .max_o     (max_o),
        .val_o     (val_o),
        .osc_o     (osc_o),
        .cfg_err_o (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_cfg(input int com, input int mn, input int mx);
        load_i    = 1'b1;
        cfg_com_i = 2'(com);
        cfg_min_i = VALSIZE'(mn);
        cfg_max_i = VALSIZE'(mx);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_com"}, int'(com_o), 2);
        check_eq({tag, "_min"}, int'(min_o), 0);
        check_eq({tag, "_max"}, int'(max_o), 15);
        check_eq({tag, "_val"}, int'(val_o), 0);
        check_eq({tag, "_osc"}, int'(osc_o), 0);
        check_eq({tag, "_err"}, int'(cfg_err_o), 0);
    endtask

    int sweep_exp [11] = '{3, 3, 4, 4, 5, 5, 4, 4, 3, 3, 4};

    initial begin
        // 1. reset, with a valid load asserted during reset
        rst_i    = 1'b1;
        sweep_i  = 1'b0;
        osc_en_i = 1'b1;
        val_i    = '0;
        load_cfg(0, 3, 12);
        tick();
        tick();
        check_reset_state("rst");
        rst_i  = 1'b0;
        load_i = 1'b0;
        tick();
        check_reset_state("idle");

        // 2. valid load and oscillator phase
        load_cfg(0, 3, 12);
        tick();
        load_i = 1'b0;
        check_eq("load_com", int'(com_o), 0);
        check_eq("load_min", int'(min_o), 3);
        check_eq("load_max", int'(max_o), 12);
        check_eq("osc_c1", int'(osc_o), 1);
        for (int c = 2; c <= 12; c++) begin
            tick();
            check_eq($sformatf("osc_c%0d", c), int'(osc_o), (c <= 4) ? 1 : ((c <= 8) ? 0 : 1));
        end
        osc_en_i = 1'b0;
        tick();
        check_eq("osc_dis", int'(osc_o), 0);
        tick();
        osc_en_i = 1'b1;
        tick();
        tick();
        tick();
        check_eq("osc_reen_3", int'(osc_o), 0);
        tick();
        check_eq("osc_reen_4", int'(osc_o), 1);

        // 3. rejected loads then a valid one
        load_cfg(1, 9, 9);
        tick();
        check_eq("rej_eq_err", int'(cfg_err_o), 1);
        check_eq("rej_eq_min", int'(min_o), 3);
        check_eq("rej_eq_max", int'(max_o), 12);
        load_cfg(1, 10, 2);
        tick();
        load_i = 1'b0;
        check_eq("rej_gt_err", int'(cfg_err_o), 1);
        check_eq("rej_gt_com", int'(com_o), 0);
        check_eq("rej_gt_min", int'(min_o), 3);
        check_eq("rej_gt_max", int'(max_o), 12);
        tick();
        check_eq("err_sticky", int'(cfg_err_o), 1);
        load_cfg(1, 1, 14);
        tick();
        load_i = 1'b0;
        check_eq("ok_err", int'(cfg_err_o), 0);
        check_eq("ok_com", int'(com_o), 1);
        check_eq("ok_min", int'(min_o), 1);
        check_eq("ok_max", int'(max_o), 14);

        // 4. pass-through, no clamping
        val_i = 4'd0;
        tick();
        check_eq("pass_0", int'(val_o), 0);
        val_i = 4'd7;
        tick();
        check_eq("pass_7", int'(val_o), 7);
        val_i = 4'd15;
        tick();
        check_eq("pass_15", int'(val_o), 15);

        // 5. sweep 3..5
        load_cfg(0, 3, 5);
        tick();
        load_i  = 1'b0;
        sweep_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            check_eq($sformatf("sweep_%0d", i), int'(val_o), sweep_exp[i]);
        end
        sweep_i = 1'b0;
        val_i   = 4'd8;
        tick();
        check_eq("sweep_exit", int'(val_o), 8);

        // 6. loads on a step edge while sweeping at 4 going up
        sweep_i = 1'b1;
        tick();
        check_eq("s6_a", int'(val_o), 3);
        tick();
        check_eq("s6_b", int'(val_o), 3);
        tick();
        check_eq("s6_c", int'(val_o), 4);
        tick();
        check_eq("s6_d", int'(val_o), 4);
        load_cfg(0, 8, 8);
        tick();
        load_i = 1'b0;
        check_eq("s6_rej_val", int'(val_o), 5);
        check_eq("s6_rej_err", int'(cfg_err_o), 1);
        tick();
        check_eq("s6_f", int'(val_o), 5);
        tick();
        check_eq("s6_g", int'(val_o), 4);
        tick();
        check_eq("s6_h", int'(val_o), 4);
        load_cfg(0, 6, 10);
        tick();
        load_i = 1'b0;
        check_eq("s6_ld_val", int'(val_o), 6);
        check_eq("s6_ld_min", int'(min_o), 6);
        check_eq("s6_ld_max", int'(max_o), 10);
        check_eq("s6_ld_err", int'(cfg_err_o), 0);
        tick();
        check_eq("s6_hold6", int'(val_o), 6);
        tick();
        check_eq("s6_up7", int'(val_o), 7);

        // reset in the middle of a sweep, with a load pending
        rst_i = 1'b1;
        load_cfg(1, 2, 9);
        tick();
        rst_i   = 1'b0;
        load_i  = 1'b0;
        sweep_i = 1'b0;
        val_i   = 4'd0;
        check_reset_state("midrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
